// File: rtl/fml_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// fml_arbiter_pkg
//   Shared constants and types for the four-master FML arbiter.
//   FML_NMASTERS : number of masters sharing the FML slave port
//   FML_BURST    : write data beats that follow each write eack
//   FML_GRANT_W  : width of the grant / write-owner index
//   FML_WCNT_W   : width of the write-beat down-counter (holds 0..FML_BURST)
// -----------------------------------------------------------------------------
package fml_arbiter_pkg;

  localparam int FML_NMASTERS = 4;
  localparam int FML_BURST    = 4;
  localparam int FML_GRANT_W  = 2;
  localparam int FML_WCNT_W   = 3;

  typedef logic [FML_GRANT_W-1:0] grant_t;
  typedef logic [FML_WCNT_W-1:0]  wcnt_t;

  // Index 'k' positions after 'g', wrapping modulo the master count.
  function automatic grant_t grant_add(input grant_t g, input int unsigned k);
    return g + grant_t'(k);
  endfunction

endpackage

// File: rtl/fml_arbiter_rr.sv
// -----------------------------------------------------------------------------
// fml_arbiter_rr
//   Purely combinational round-robin picker. Starting one position after the
//   current grant, returns the first requesting master; the current grant is
//   looked at last so a master that keeps requesting is only re-picked when
//   nobody else wants the port. With no request at all the grant is returned
//   unchanged.
//
//   grant      in  FML_GRANT_W   current grant
//   req        in  FML_NMASTERS  request vector, bit N = master N stb
//   next_grant out FML_GRANT_W   proposed grant for the next cycle
// -----------------------------------------------------------------------------
module fml_arbiter_rr
  import fml_arbiter_pkg::*;
(
  input  logic [FML_GRANT_W-1:0]  grant,
  input  logic [FML_NMASTERS-1:0] req,
  output logic [FML_GRANT_W-1:0]  next_grant
);

  logic                   found;
  logic [FML_GRANT_W-1:0] cand;

  always_comb begin
    next_grant = grant;
    found      = 1'b0;
    cand       = grant;
    // k runs 1..N so the final candidate is the current grant itself.
    for (int unsigned k = 1; k <= FML_NMASTERS; k++) begin
      cand = grant_add(grant, k);
      if (!found && req[cand]) begin
        next_grant = cand;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fml_arbiter.sv
// -----------------------------------------------------------------------------
// fml_arbiter
//   Four-master FML 4x64 arbiter sitting directly in front of the DDR SDRAM
//   controller. One master at a time owns the command path (round robin);
//   write bursts are steered from the master whose write was acknowledged;
//   read data is broadcast.
//
//   sys_clk, sys_rst         clock / synchronous active-high reset
//   mN_adr/stb/we/sel/di     master N command and write data (N = 0..3)
//   mN_eack                  master N command acknowledge
//   mN_do                    read data, every master sees s_do
//   s_adr/stb/we/sel/di      to controller fml_adr/stb/we/sel/di
//   s_eack, s_do             from controller fml_eack/fml_do
// -----------------------------------------------------------------------------
module fml_arbiter
  import fml_arbiter_pkg::*;
#(
  parameter int sdram_depth = 26
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,

  input  logic [sdram_depth-1:0] m0_adr,
  input  logic                   m0_stb,
  input  logic                   m0_we,
  output logic                   m0_eack,
  input  logic [7:0]             m0_sel,
  input  logic [63:0]            m0_di,
  output logic [63:0]            m0_do,

  input  logic [sdram_depth-1:0] m1_adr,
  input  logic                   m1_stb,
  input  logic                   m1_we,
  output logic                   m1_eack,
  input  logic [7:0]             m1_sel,
  input  logic [63:0]            m1_di,
  output logic [63:0]            m1_do,

  input  logic [sdram_depth-1:0] m2_adr,
  input  logic                   m2_stb,
  input  logic                   m2_we,
  output logic                   m2_eack,
  input  logic [7:0]             m2_sel,
  input  logic [63:0]            m2_di,
  output logic [63:0]            m2_do,

  input  logic [sdram_depth-1:0] m3_adr,
  input  logic                   m3_stb,
  input  logic                   m3_we,
  output logic                   m3_eack,
  input  logic [7:0]             m3_sel,
  input  logic [63:0]            m3_di,
  output logic [63:0]            m3_do,

  output logic [sdram_depth-1:0] s_adr,
  output logic                   s_stb,
  output logic                   s_we,
  input  logic                   s_eack,
  output logic [7:0]             s_sel,
  output logic [63:0]            s_di,
  input  logic [63:0]            s_do
);

  // ---------------------------------------------------------------------------
  // Gather per-master inputs into indexable form
  // ---------------------------------------------------------------------------
  logic [sdram_depth-1:0]  adr_a [FML_NMASTERS];
  logic [7:0]              sel_a [FML_NMASTERS];
  logic [63:0]             di_a  [FML_NMASTERS];
  logic [FML_NMASTERS-1:0] stb_v;
  logic [FML_NMASTERS-1:0] we_v;
  logic [FML_NMASTERS-1:0] eack_v;

  assign adr_a[0] = m0_adr;
  assign adr_a[1] = m1_adr;
  assign adr_a[2] = m2_adr;
  assign adr_a[3] = m3_adr;

  assign sel_a[0] = m0_sel;
  assign sel_a[1] = m1_sel;
  assign sel_a[2] = m2_sel;
  assign sel_a[3] = m3_sel;

  assign di_a[0]  = m0_di;
  assign di_a[1]  = m1_di;
  assign di_a[2]  = m2_di;
  assign di_a[3]  = m3_di;

  assign stb_v    = {m3_stb, m2_stb, m1_stb, m0_stb};
  assign we_v     = {m3_we, m2_we, m1_we, m0_we};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [FML_GRANT_W-1:0] grant_q,  grant_d;
  logic [FML_GRANT_W-1:0] wowner_q, wowner_d;
  logic [FML_WCNT_W-1:0]  wcnt_q,   wcnt_d;

  logic [FML_GRANT_W-1:0] rr_next;
  logic                   advance;
  logic                   wr_accept;

  fml_arbiter_rr u_rr (
    .grant      (grant_q),
    .req        (stb_v),
    .next_grant (rr_next)
  );

  // ---------------------------------------------------------------------------
  // Command path: combinational from the granted master
  // ---------------------------------------------------------------------------
  assign s_adr = adr_a[grant_q];
  assign s_we  = we_v[grant_q];
  assign s_stb = stb_v[grant_q] & ~sys_rst;

  generate
    for (genvar gi = 0; gi < FML_NMASTERS; gi++) begin : g_eack
      assign eack_v[gi] = s_eack & ~sys_rst & (grant_q == FML_GRANT_W'(gi));
    end
  endgenerate

  assign m0_eack = eack_v[0];
  assign m1_eack = eack_v[1];
  assign m2_eack = eack_v[2];
  assign m3_eack = eack_v[3];

  // Read data is broadcast; masters track their own outstanding reads.
  assign m0_do = s_do;
  assign m1_do = s_do;
  assign m2_do = s_do;
  assign m3_do = s_do;

  // ---------------------------------------------------------------------------
  // Grant rotation: only move on once the owner has been served or has
  // dropped its request, so a pending command is never pre-empted.
  // ---------------------------------------------------------------------------
  assign advance   = ~stb_v[grant_q] | s_eack;
  assign wr_accept = s_eack & s_we;

  always_comb begin
    grant_d = grant_q;
    if (advance) begin
      grant_d = rr_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Write burst tracking. A new write eack always reloads, which also covers
  // back-to-back bursts where the eack lands on the final beat.
  // ---------------------------------------------------------------------------
  always_comb begin
    wowner_d = wowner_q;
    wcnt_d   = wcnt_q;
    if (wr_accept) begin
      wowner_d = grant_q;
      wcnt_d   = FML_WCNT_W'(FML_BURST);
    end else if (wcnt_q != '0) begin
      wcnt_d   = wcnt_q - 1'b1;
    end
  end

  // Outside a burst all bytes are masked; data then just follows m0.
  always_comb begin
    s_sel = '0;
    s_di  = di_a[0];
    if (wcnt_q != '0) begin
      s_sel = sel_a[wowner_q];
      s_di  = di_a[wowner_q];
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      grant_q  <= '0;
      wowner_q <= '0;
      wcnt_q   <= '0;
    end else begin
      grant_q  <= grant_d;
      wowner_q <= wowner_d;
      wcnt_q   <= wcnt_d;
    end
  end

endmodule

// File: tb/tb_fml_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fml_arbiter
//   Self-checking bench for fml_arbiter: a table of arbitration vectors, a few
//   hand-written burst sequences, and a randomized run against a cycle-level
//   reference model (grant by rule, write beats scheduled by absolute cycle).
// -----------------------------------------------------------------------------
module tb_fml_arbiter;

  localparam int AW = 26;

  logic          clk;
  logic          rst;
  logic [AW-1:0] adr [4];
  logic [3:0]    stb;
  logic [3:0]    we;
  logic [7:0]    sel [4];
  logic [63:0]   di  [4];
  logic          s_eack;
  logic [63:0]   s_do;

  logic [AW-1:0] s_adr;
  logic          s_stb;
  logic          s_we;
  logic [7:0]    s_sel;
  logic [63:0]   s_di;
  logic [3:0]    eack;
  logic [63:0]   mdo [4];

  fml_arbiter #(.sdram_depth(AW)) dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .m0_adr  (adr[0]), .m0_stb (stb[0]), .m0_we (we[0]), .m0_eack (eack[0]),
    .m0_sel  (sel[0]), .m0_di  (di[0]),  .m0_do (mdo[0]),
    .m1_adr  (adr[1]), .m1_stb (stb[1]), .m1_we (we[1]), .m1_eack (eack[1]),
    .m1_sel  (sel[1]), .m1_di  (di[1]),  .m1_do (mdo[1]),
    .m2_adr  (adr[2]), .m2_stb (stb[2]), .m2_we (we[2]), .m2_eack (eack[2]),
    .m2_sel  (sel[2]), .m2_di  (di[2]),  .m2_do (mdo[2]),
    .m3_adr  (adr[3]), .m3_stb (stb[3]), .m3_we (we[3]), .m3_eack (eack[3]),
    .m3_sel  (sel[3]), .m3_di  (di[3]),  .m3_do (mdo[3]),
    .s_adr   (s_adr),
    .s_stb   (s_stb),
    .s_we    (s_we),
    .s_eack  (s_eack),
    .s_sel   (s_sel),
    .s_di    (s_di),
    .s_do    (s_do)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model state: current owner of the command port, and for every
  // absolute cycle the master whose write beat is due then (-1 = none).
  int m_grant = 0;
  int sched [0:8191];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // Compare every output against the model; called away from the clock edge.
  task automatic cyc_check();
    int g;
    int own;
    @(negedge clk);
    g   = m_grant;
    own = sched[cyc];
    chk("s_adr", s_adr, adr[g]);
    chk("s_stb", s_stb, rst ? 1'b0 : stb[g]);
    chk("s_we",  s_we,  we[g]);
    for (int n = 0; n < 4; n++) begin
      chk("m_eack", eack[n], (!rst && s_eack && g == n));
      chk("m_do",   mdo[n],  s_do);
    end
    if (own >= 0) begin
      chk("s_sel", s_sel, sel[own]);
      chk("s_di",  s_di,  di[own]);
    end else begin
      chk("s_sel", s_sel, 8'h00);
      chk("s_di",  s_di,  di[0]);
    end
  endtask

  // Advance the model with this cycle's inputs, then move to the next cycle.
  task automatic cyc_end();
    int nxt;
    if (rst) begin
      m_grant = 0;
      for (int k = cyc + 1; k <= cyc + 8; k++) sched[k] = -1;
    end else begin
      if (s_eack && we[m_grant]) begin
        for (int k = 1; k <= 4; k++) sched[cyc + k] = m_grant;
      end
      if (!stb[m_grant] || s_eack) begin
        nxt = m_grant;
        for (int k = 1; k <= 4; k++) begin
          if (stb[(m_grant + k) % 4]) begin
            nxt = (m_grant + k) % 4;
            break;
          end
        end
        m_grant = nxt;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step();
    cyc_check();
    cyc_end();
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    stb    = 4'b0000;
    we     = 4'b0000;
    s_eack = 1'b0;
    step();
    step();
    rst    = 1'b0;
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] stb;
    logic       eack_in;
    logic       exp_stb;
    logic [3:0] exp_eack;
    int         exp_grant;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic [3:0] s, input logic e,
                              input logic es, input logic [3:0] ee, input int g);
    vec_t v;
    v.rst = r; v.stb = s; v.eack_in = e;
    v.exp_stb = es; v.exp_eack = ee; v.exp_grant = g;
    return v;
  endfunction

  initial begin
    vec_t vt [15];
    int   cnt;

    for (int k = 0; k < 8192; k++) sched[k] = -1;
    adr[0] = 26'h0000010; adr[1] = 26'h0000020;
    adr[2] = 26'h0000100; adr[3] = 26'h0000030;
    for (int n = 0; n < 4; n++) begin
      sel[n] = 8'h01 << n;
      di[n]  = 64'hA0A0_0000_0000_0000 + 64'(n);
    end
    s_do = 64'h0123_4567_89AB_CDEF;
    rst = 1'b1; stb = '0; we = '0; s_eack = 1'b0;

    // ---- table: reset, idle, then m0/m1/m3 continuous with eack every 2 ----
    vt[0]  = mk(1'b1, 4'b1111, 1'b1, 1'b0, 4'b0000, 0);
    vt[1]  = mk(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 0);
    vt[2]  = mk(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 0);
    vt[3]  = mk(1'b0, 4'b1011, 1'b0, 1'b1, 4'b0000, 0);
    vt[4]  = mk(1'b0, 4'b1011, 1'b1, 1'b1, 4'b0001, 0);
    vt[5]  = mk(1'b0, 4'b1011, 1'b0, 1'b1, 4'b0000, 1);
    vt[6]  = mk(1'b0, 4'b1011, 1'b1, 1'b1, 4'b0010, 1);
    vt[7]  = mk(1'b0, 4'b1011, 1'b0, 1'b1, 4'b0000, 3);
    vt[8]  = mk(1'b0, 4'b1011, 1'b1, 1'b1, 4'b1000, 3);
    vt[9]  = mk(1'b0, 4'b1011, 1'b0, 1'b1, 4'b0000, 0);
    vt[10] = mk(1'b0, 4'b1011, 1'b1, 1'b1, 4'b0001, 0);
    vt[11] = mk(1'b0, 4'b1011, 1'b0, 1'b1, 4'b0000, 1);
    vt[12] = mk(1'b0, 4'b1011, 1'b1, 1'b1, 4'b0010, 1);
    vt[13] = mk(1'b0, 4'b1011, 1'b0, 1'b1, 4'b0000, 3);
    vt[14] = mk(1'b0, 4'b1011, 1'b1, 1'b1, 4'b1000, 3);

    do_reset();
    for (int i = 0; i < 15; i++) begin
      rst = vt[i].rst; stb = vt[i].stb; s_eack = vt[i].eack_in; we = 4'b0000;
      cyc_check();
      chk($sformatf("tab%0d_stb", i),   s_stb, vt[i].exp_stb);
      chk($sformatf("tab%0d_eack", i),  eack,  vt[i].exp_eack);
      chk($sformatf("tab%0d_grant", i), s_adr, adr[vt[i].exp_grant]);
      chk($sformatf("tab%0d_sel", i),   s_sel, 8'h00);
      cyc_end();
    end

    // ---- m2 single write at 0x100, eack on the third presented cycle ----
    do_reset();
    stb = 4'b0100; we = 4'b0100;
    step();                                   // grant moves 0 -> 2
    cnt = 0;
    for (int j = 0; j < 3; j++) begin
      s_eack = (j == 2);
      cyc_check();
      chk("w1_adr", s_adr, 26'h0000100);
      chk("w1_stb", s_stb, 1'b1);
      cnt += int'(eack[2]);
      cyc_end();
    end
    stb = 4'b0000; s_eack = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      sel[2] = 8'h10 + 8'(i);
      di[2]  = 64'hD200_0000 + 64'(i);
      cyc_check();
      chk("w1_di",  s_di,  64'hD200_0000 + 64'(i));
      chk("w1_sel", s_sel, 8'h10 + 8'(i));
      cnt += int'(eack[2]);
      cyc_end();
    end
    cyc_check();
    chk("w1_sel_end", s_sel, 8'h00);
    chk("w1_eack_cnt", cnt, 1);
    cyc_end();

    // ---- m1 write then m3 write 4 cycles later: 8 contiguous beats ----
    do_reset();
    sel[1] = 8'h0F; sel[3] = 8'hF0; we = 4'b1010;
    stb = 4'b0010;
    step();                                   // grant moves 0 -> 1
    stb = 4'b1010; s_eack = 1'b1;
    step();                                   // m1 eack, grant -> 3
    stb = 4'b1000;
    for (int k = 1; k <= 8; k++) begin
      s_eack = (k == 4);
      if (k > 4) stb = 4'b0000;
      di[1] = 64'h1100 + 64'(k);
      di[3] = 64'h3300 + 64'(k);
      cyc_check();
      chk("w2_sel_nz", s_sel != 8'h00, 1'b1);
      chk("w2_di", s_di, (k <= 4) ? 64'h1100 + 64'(k) : 64'h3300 + 64'(k));
      cyc_end();
    end
    stb = 4'b0000; s_eack = 1'b0;
    cyc_check();
    chk("w2_sel_end", s_sel, 8'h00);
    cyc_end();

    // ---- m0 read eack on beat 2 of an m2 write burst ----
    do_reset();
    sel[2] = 8'h3C; we = 4'b0100; stb = 4'b0100;
    step();                                   // grant moves 0 -> 2
    stb = 4'b0101; s_eack = 1'b1;
    step();                                   // m2 write eack, grant -> 0
    for (int k = 1; k <= 4; k++) begin
      stb    = (k <= 2) ? 4'b0001 : 4'b0000;
      s_eack = (k == 2);
      di[2]  = 64'h2200 + 64'(k);
      s_do   = 64'hBEEF_0000 + 64'(k);
      cyc_check();
      if (k == 2) chk("w3_read_eack", eack, 4'b0001);
      if (k >= 3) chk("w3_di_m2", s_di, 64'h2200 + 64'(k));
      chk("w3_do_bcast", mdo[3], 64'hBEEF_0000 + 64'(k));
      cyc_end();
    end

    // ---- reset on beat 2 of a write burst ----
    do_reset();
    sel[2] = 8'hFF; we = 4'b0100; stb = 4'b0100;
    step();
    s_eack = 1'b1;
    step();                                   // m2 write eack
    s_eack = 1'b0; stb = 4'b0000;
    step();                                   // beat 1
    rst = 1'b1; stb = 4'b1111; s_eack = 1'b1;
    cyc_check();                              // beat 2 under reset
    chk("w4_rst_eack", eack, 4'b0000);
    chk("w4_rst_stb",  s_stb, 1'b0);
    cyc_end();
    rst = 1'b0; stb = 4'b0000; s_eack = 1'b0;
    cyc_check();
    chk("w4_sel_after", s_sel, 8'h00);
    chk("w4_grant0",    s_adr, adr[0]);
    cyc_end();

    // ---- randomized traffic against the reference model ----
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int n = 0; n < 4; n++) begin
        stb[n] = ($urandom_range(0, 3) != 0);
        we[n]  = 1'($urandom());
        sel[n] = 8'($urandom());
        di[n]  = {$urandom(), $urandom()};
        adr[n] = AW'($urandom());
      end
      s_do   = {$urandom(), $urandom()};
      s_eack = stb[m_grant] && ($urandom_range(0, 2) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fml_arbiter.md
# fml_arbiter

Four-master FML 4x64 arbiter placed directly upstream of the DDR SDRAM controller, driving its `fml_*` port. Grants the shared FML slave port to one master at a time in round-robin order and forwards that master's command. Tracks ownership of each 4-beat write burst so write data and byte selects reach the controller from the master whose command was acknowledged. Broadcasts read data to all masters.

## Interface
- `sdram_depth`, 26, FML byte-address width; must match the controller.
- `sys_clk` in 1, sole clock.
- `sys_rst` in 1, synchronous, active-high reset.
- `mN_adr` in `sdram_depth` (N=0..3), master N address.
- `mN_stb` in 1, master N request.
- `mN_we` in 1, master N write.
- `mN_eack` out 1, master N command acknowledge.
- `mN_sel` in 8, master N write byte selects.
- `mN_di` in 64, master N write data.
- `mN_do` out 64, read data (all four driven from `s_do`).
- `s_adr` out `sdram_depth`, to the controller's `fml_adr`.
- `s_stb` out 1, to `fml_stb`.
- `s_we` out 1, to `fml_we`.
- `s_eack` in 1, from `fml_eack`.
- `s_sel` out 8, to `fml_sel`.
- `s_di` out 64, to `fml_di`.
- `s_do` in 64, from `fml_do`.

## Operation
- Grant register `grant` (2 bits) selects the master for `s_adr`/`s_stb`/`s_we`. All three are combinational from the selected master's inputs.
- `mN_eack = s_eack & (grant == N)`. `mN_do = s_do` for every N.
- Grant update is registered and evaluated every cycle.
  - If the granted master has `stb=0`, or `s_eack=1` this cycle, the next grant is the first requesting master in order grant+1, grant+2, grant+3, grant (wrapping).
  - If no master requests, the grant is unchanged.
  - Otherwise the grant is held. A pending request is never pre-empted before its eack.
- Write burst tracking:
  - On `s_eack & s_we`: load `wowner <= grant` and `wcnt <= 4`.
  - While `wcnt != 0`: `s_di = m[wowner]_di`, `s_sel = m[wowner]_sel`, and `wcnt` decrements each cycle.
  - While `wcnt == 0`: `s_sel = 0` (all bytes masked) and `s_di = m0_di`.
- Simultaneous events:
  - A write eack while `wcnt != 0` reloads `wowner`/`wcnt`; the newer command wins. The controller guarantees burst spacing.
  - An eack on the last data beat (`wcnt == 1`) reloads to 4 with no gap.
- Read eacks do not touch `wowner`/`wcnt`. Read data routing needs no tracking because it is broadcast.
- During `sys_rst`: `s_stb` and all `mN_eack` are forced 0. On the reset clock edge, `grant <= 0`, `wowner <= 0`, `wcnt <= 0`.
- Reset in the middle of a burst abandons the burst. `s_sel` is 0 from the cycle after the reset edge.

## Timing
- Command path is combinational: master `stb` to `s_stb`, zero added latency when already granted.
- Grant switch costs 1 cycle. A master newly selected at edge k sees its command on `s_stb` from cycle k.
- The eack cycle is the last cycle the command is presented. The grant rotates at the following edge.
- A master whose stb stays high after its eack is treated as a new request. It is re-granted immediately only if no other master requests.
- Write data beats: the cycles eack+1 .. eack+4, relative to `s_eack`. Masters present beat i on cycle eack+i.
- Read data: passes through the arbiter with zero cycles of delay; the controller's latency is unchanged.

## Structure
- Package `fml_arbiter_pkg` holds:
  - `FML_NMASTERS = 4`
  - `FML_BURST = 4`
  - `FML_GRANT_W = 2`
  - the `wcnt` width (3)
- Sub-module `fml_arbiter_rr`: purely combinational next-grant picker. Inputs are the current grant and the 4-bit request vector; output is the next grant.
- The top level holds the grant and burst registers and the muxes.

## Test plan
- Reset, then idle → `s_stb=0`, `s_sel=0`, `grant=0`.
- m2 single write at adr 0x100, eack after 3 cycles → `s_adr=0x100` throughout, `m2_eack` for exactly one cycle, and `s_di`/`s_sel` equal m2's data/sel on eack+1..+4.
- m0, m1, m3 requesting continuously with eack every 2 cycles → grant order 0,1,3,0,1,3; no master receives two consecutive eacks.
- m1 write eack, then m3 write eack 4 cycles later → contiguous 8 beats: 4 from m1, then 4 from m3, with `s_sel` never 0 between.
- m0 read eack while m2's write burst is on beat 2 → beats 3–4 still come from m2, and `s_do` appears on all `mN_do`.
- `sys_rst` asserted on beat 2 of a write → `s_sel=0` from the cycle after the reset edge, `grant=0`, no eack during reset.
